axis_hist_store: RTL and testbench

Stream sink that captures the 32-bit word stream leaving the histogram stage into an on-chip buffer and exposes it through a simple registered read port. It sits directly downstream of `s_m_hist` and replaces the plain RAM sink. It adds a write pointer, fill count, full/overflow status and a synchronous clear, so software or a test harness can read back exactly what the histogram produced.

---
 rtl/axis_hist_store.sv | 93 +++++++++
 tb/tb_axis_hist_store.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/axis_hist_store.sv
// Stream sink that captures the histogram output words into on-chip memory with a registered read port.
// Define HIST_STORE_WRAP_EN to overwrite the oldest words when full; otherwise the input stalls until clear.
module axis_hist_store #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  clear,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  overflow
);

`ifdef HIST_STORE_WRAP_EN
  localparam bit WRAP_MODE = 1'b1;
`else
  localparam bit WRAP_MODE = 1'b0;
`endif

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic w_full;
  logic w_ready;
  logic w_accept;
  logic w_ovf_event;

  assign w_full   = (r_count == FULL_COUNT);
  assign w_ready  = !areset && !clear && (WRAP_MODE || !w_full);
  assign w_accept = s_axis_tvalid && w_ready;
  // Wrap mode flags lost data; stall mode flags back-pressure seen by the upstream.
  assign w_ovf_event = WRAP_MODE ? (w_accept && w_full) : (s_axis_tvalid && w_full);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
        if (!w_full) r_count <= r_count + (ADDR_WIDTH + 1)'(1);
      end
      if (w_ovf_event) r_overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset so it can map onto block RAM.
  always_ff @(posedge aclk) begin
    if (w_accept) r_mem[r_wr_ptr] <= s_axis_tdata;
  end

  // Reading the array in the same edge as a write returns the old word (read-first).
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= r_mem[rd_addr];
    end
  end

  assign s_axis_tready = w_ready;
  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign wr_ptr        = r_wr_ptr;
  assign count         = r_count;
  assign full          = w_full;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_axis_hist_store.sv
// Self-checking bench for axis_hist_store (DEPTH=8): reference model plus read-data scoreboard queue.
// Mode-specific scenarios follow HIST_STORE_WRAP_EN, matching however the design is built.
module tb_axis_hist_store;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

`ifdef HIST_STORE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          clear;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;

  axis_hist_store #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .clear         (clear),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .wr_ptr        (wr_ptr),
    .count         (count),
    .full          (full),
    .overflow      (overflow)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr   = 0;
  int            m_count = 0;
  bit            m_ovf   = 1'b0;
  logic [DW-1:0] rd_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read results are compared as the DUT presents them, in request order.
  always @(negedge aclk) begin
    if (rd_valid === 1'b1) begin
      if (rd_q.size() == 0) check("rd_valid_unrequested", 1, 0);
      else check("rd_data", rd_data, rd_q.pop_front());
    end
  end

  // One clock cycle: drive inputs, check ready, update model at the edge, check status after it.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit clr,
                      input bit re, input int ra, input bit rst);
    bit m_full, rdy, acc;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    clear         = clr;
    rd_en         = re;
    rd_addr       = AW'(ra);
    areset        = rst;
    m_full = (m_count == DEPTH);
    rdy    = !rst && !clr && (WRAP || !m_full);
    acc    = v && rdy;
    #1;
    check("tready", s_axis_tready, rdy);
    if (re && !rst) rd_q.push_back(m_mem[ra]);
    @(posedge aclk);
    if (rst || clr) begin
      m_ptr = 0; m_count = 0; m_ovf = 1'b0;
    end else begin
      if (acc) begin
        m_mem[m_ptr] = d;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_count < DEPTH) m_count++;
      end
      if (WRAP ? (acc && m_full) : (v && m_full)) m_ovf = 1'b1;
    end
    #1;
    check("wr_ptr", wr_ptr, m_ptr);
    check("count", count, m_count);
    check("full", full, m_count == DEPTH);
    check("overflow", overflow, m_ovf);
    check("rd_valid", rd_valid, re && !rst);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic read(input int a);
    step(1'b0, '0, 1'b0, 1'b1, a, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, '0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; clear = 1'b0;
    rd_en = 1'b0; rd_addr = '0; areset = 1'b1;
    @(posedge aclk); #1;

    // Reset held for two cycles, then reset values.
    step(1'b0, '0, 1'b0, 1'b0, 0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 0, 1'b1);
    #1;
    check("reset_rd_data", rd_data, 0);
    check("reset_count", count, 0);
    idle();

    // Six-beat stream and read-back of addresses 0..5.
    for (int i = 0; i < 6; i++) push(DW'(32'h10 + i));
    check("stream_count", count, 6);
    check("stream_wr_ptr", wr_ptr, 6);
    for (int i = 0; i < 6; i++) read(i);
    idle();

    do_clear();
    if (!WRAP) begin
      // Ten beats offered: eight land, the rest see back-pressure.
      for (int i = 0; i < 10; i++) step(1'b1, DW'(32'h20 + i), 1'b0, 1'b0, 0, 1'b0);
      check("stall_full", full, 1);
      check("stall_tready", s_axis_tready, 0);
      check("stall_overflow", overflow, 1);
      do_clear();
      check("stall_clear_count", count, 0);
      push(DW'(32'h28));
      push(DW'(32'h29));
      read(0); read(1); read(2);
    end else begin
      // Beats 1..10 into eight slots overwrite the two oldest.
      for (int i = 1; i <= 10; i++) push(DW'(i));
      check("wrap_count", count, 8);
      check("wrap_wr_ptr", wr_ptr, 2);
      check("wrap_overflow", overflow, 1);
      read(0); read(1); read(2);
    end
    idle();

    // Same-cycle read and write of address 3 returns the old word, then the new one.
    do_clear();
    push(DW'(32'h01)); push(DW'(32'h02)); push(DW'(32'h03)); push(DW'(32'hAA));
    do_clear();
    push(DW'(32'h01)); push(DW'(32'h02)); push(DW'(32'h03));
    step(1'b1, DW'(32'hBB), 1'b0, 1'b1, 3, 1'b0);
    read(3);
    idle();

    // Random traffic with a reset pulse in the middle of the burst.
    do_clear();
    for (int c = 0; c < 200; c++) begin
      bit rst, clr;
      rst = (c == 100 || c == 101);
      clr = ($urandom_range(0, 15) == 0);
      step(bit'($urandom_range(0, 1)), $urandom, clr, bit'($urandom_range(0, 1)),
           $urandom_range(0, DEPTH - 1), rst);
      if (c == 101) begin
        #1;
        check("midreset_rd_data", rd_data, 0);
        check("midreset_count", count, 0);
      end
    end
    idle();
    idle();
    check("rd_queue_drained", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
